sha_pre_pipeline_scheduler: RTL and testbench

//  Sequences one SHA pre-pipeline processor through a nonce sweep. Accepts a work item (midstate + w1..w3),

---
 rtl/sha_pre_pipeline_scheduler_pkg.sv | 30 +++
 rtl/sha_pre_pipeline_scheduler.sv | 177 +++++++++++++++++
 tb/tb_sha_pre_pipeline_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_pre_pipeline_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// sha_pre_pipeline_scheduler_pkg
//
// Purpose : Shared SHA types for the pre-pipeline scheduler.
//           - HashState     : eight 32-bit midstate words
//           - sched_state_t : scheduler FSM states
//           - nonce_t       : 33-bit nonce so the sweep can step past
//                             2^32-1 without wrapping back to low nonces
// Ports   : none (package)
// ----------------------------------------------------------------------------
package sha_pre_pipeline_scheduler_pkg;

   typedef logic [7:0][31:0] HashState;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

   localparam int unsigned NONCE_W = 33;

   typedef logic [NONCE_W-1:0] nonce_t;

   // The slice is exhausted once the next nonce would reach the exclusive bound.
   function automatic logic slice_exhausted(input nonce_t next_nonce, input nonce_t limit);
      return (next_nonce >= limit);
   endfunction

endpackage

// File: rtl/sha_pre_pipeline_scheduler.sv
// ----------------------------------------------------------------------------
// sha_pre_pipeline_scheduler
//
// Purpose : Sequences one SHA pre-pipeline processor through a nonce sweep.
//           A work item (midstate + w1..w3) is accepted in IDLE, then one
//           newblock+valid cycle and one valid per nonce are issued until the
//           processor's nonce slice is exhausted. The scheduler then waits for
//           the pipeline to drain and pulses sweep_done.
//
// Optional feature : define SHA_SCHED_ABORT_EN to let 'abort' cancel a sweep
//                    in ISSUE (the drain and sweep_done still follow). When the
//                    macro is undefined the abort port is present but ignored.
//
// Ports :
//   clk, rst             clock, synchronous active-high reset
//   work_valid/ready     work item handshake (ready = IDLE and not in reset)
//   work_hashstate       midstate for the sweep
//   work_w1/w2/w3        block-2 words 0..2
//   hold                 suppress issue this cycle (ISSUE only)
//   abort                cancel current sweep (SHA_SCHED_ABORT_EN only)
//   core_valid           one nonce issued to the pre-pipeline
//   core_newblock        first issue of a work item
//   core_hashstate       registered midstate, stable for the whole sweep
//   core_w1/w2/w3        registered block-2 words, stable for the whole sweep
//   busy                 scheduler is working on an item
//   cur_nonce            nonce of the most recent issue
//   sweep_done           one-cycle pulse once the sweep has fully drained
// ----------------------------------------------------------------------------
module sha_pre_pipeline_scheduler
   import sha_pre_pipeline_scheduler_pkg::*;
#(
   parameter int unsigned  PROCESSORINDEX = 0,
   parameter int unsigned  NUMPROCESSORS  = 1,
   parameter logic [32:0]  NONCE_LIMIT    = 33'h1_0000_0000,
   parameter int unsigned  PIPE_LATENCY   = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        work_valid,
   output logic        work_ready,
   input  HashState    work_hashstate,
   input  logic [31:0] work_w1,
   input  logic [31:0] work_w2,
   input  logic [31:0] work_w3,
   input  logic        hold,
   input  logic        abort,
   output logic        core_valid,
   output logic        core_newblock,
   output HashState    core_hashstate,
   output logic [31:0] core_w1,
   output logic [31:0] core_w2,
   output logic [31:0] core_w3,
   output logic        busy,
   output logic [31:0] cur_nonce,
   output logic        sweep_done
);

   localparam int unsigned DRAIN_W = $clog2(PIPE_LATENCY + 1);

   localparam nonce_t             FIRST_NONCE = nonce_t'(PROCESSORINDEX);
   localparam nonce_t             STRIDE      = nonce_t'(NUMPROCESSORS);
   // Counting down to zero inclusive gives exactly PIPE_LATENCY drain cycles.
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD  = DRAIN_W'(PIPE_LATENCY - 1);

   sched_state_t       state_q;
   nonce_t             nonce_q;
   nonce_t             nonce_d;
   logic               first_pend_q;
   logic [DRAIN_W-1:0] drain_q;
   logic               core_valid_q;
   logic               core_newblock_q;
   HashState           hashstate_q;
   logic [31:0]        w1_q;
   logic [31:0]        w2_q;
   logic [31:0]        w3_q;
   logic               busy_q;
   logic [31:0]        cur_nonce_q;
   logic               sweep_done_q;
   logic               abort_req;

`ifdef SHA_SCHED_ABORT_EN
   assign abort_req = abort;
`else
   logic unused_abort;
   assign abort_req    = 1'b0;
   assign unused_abort = abort;
`endif

   // 33-bit add: stepping past 2^32-1 lands above NONCE_LIMIT instead of wrapping.
   assign nonce_d    = nonce_q + STRIDE;
   assign work_ready = (state_q == IDLE) & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         nonce_q         <= '0;
         first_pend_q    <= 1'b0;
         drain_q         <= '0;
         core_valid_q    <= 1'b0;
         core_newblock_q <= 1'b0;
         hashstate_q     <= '0;
         w1_q            <= '0;
         w2_q            <= '0;
         w3_q            <= '0;
         busy_q          <= 1'b0;
         cur_nonce_q     <= '0;
         sweep_done_q    <= 1'b0;
      end else begin
         core_valid_q    <= 1'b0;
         core_newblock_q <= 1'b0;
         sweep_done_q    <= 1'b0;
         // busy is registered from the state, so it trails the state by one
         // cycle and still covers the sweep_done cycle.
         busy_q          <= (state_q != IDLE);

         case (state_q)
            IDLE: begin
               if (work_valid && work_ready) begin
                  hashstate_q  <= work_hashstate;
                  w1_q         <= work_w1;
                  w2_q         <= work_w2;
                  w3_q         <= work_w3;
                  nonce_q      <= FIRST_NONCE;
                  first_pend_q <= 1'b1;
                  // An empty slice skips straight to the drain so the
                  // consumer still sees sweep_done.
                  if (slice_exhausted(FIRST_NONCE, NONCE_LIMIT)) begin
                     state_q <= DRAIN;
                     drain_q <= DRAIN_LOAD;
                  end else begin
                     state_q <= ISSUE;
                  end
               end
            end

            ISSUE: begin
               if (abort_req) begin
                  state_q <= DRAIN;
                  drain_q <= DRAIN_LOAD;
               end else if (!hold) begin
                  core_valid_q    <= 1'b1;
                  core_newblock_q <= first_pend_q;
                  cur_nonce_q     <= nonce_q[31:0];
                  first_pend_q    <= 1'b0;
                  nonce_q         <= nonce_d;
                  if (slice_exhausted(nonce_d, NONCE_LIMIT)) begin
                     state_q <= DRAIN;
                     drain_q <= DRAIN_LOAD;
                  end
               end
            end

            DRAIN: begin
               if (drain_q == '0) begin
                  sweep_done_q <= 1'b1;
                  state_q      <= IDLE;
               end else begin
                  drain_q <= drain_q - DRAIN_W'(1);
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign core_valid     = core_valid_q;
   assign core_newblock  = core_newblock_q;
   assign core_hashstate = hashstate_q;
   assign core_w1        = w1_q;
   assign core_w2        = w2_q;
   assign core_w3        = w3_q;
   assign busy           = busy_q;
   assign cur_nonce      = cur_nonce_q;
   assign sweep_done     = sweep_done_q;

endmodule

// File: tb/tb_sha_pre_pipeline_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sha_pre_pipeline_scheduler
//
// Three schedulers share one stimulus stream:
//   d0 : PI=1,          NP=4, LIMIT=17          (main configuration)
//   d1 : PI=FFFF_FFF3,  NP=4, LIMIT=1_0000_0000 (top of the 32-bit nonce range)
//   d2 : PI=20,         NP=4, LIMIT=17          (empty slice)
// The reference plan for a sweep is derived from the nonce arithmetic and the
// hold/abort pattern: the i-th nonce goes out on the i-th non-held cycle after
// accept, and sweep_done follows the last issue (or the abort) by PIPE_LATENCY.
// ----------------------------------------------------------------------------
module tb_sha_pre_pipeline_scheduler;
   import sha_pre_pipeline_scheduler_pkg::*;

   localparam int PL = 15;
`ifdef SHA_SCHED_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        work_valid;
   logic        wv3;
   HashState    work_hs;
   logic [31:0] ww1, ww2, ww3;
   logic        hold;
   logic        abort;

   logic        wr  [3];
   logic        cv  [3];
   logic        nb  [3];
   HashState    chs [3];
   logic [31:0] cw1 [3];
   logic [31:0] cw2 [3];
   logic [31:0] cw3 [3];
   logic        bsy [3];
   logic [31:0] cn  [3];
   logic        sd  [3];

   int n_tests = 0;
   int n_fail  = 0;

   // expected plan per scheduler, indexed by cycle offset after accept
   bit          e_valid [3][64];
   bit          e_nb    [3][64];
   logic [31:0] e_non   [3][64];
   int          e_done  [3];
   logic [31:0] prev_cur[3];

   // expected registered work item
   HashState    x_hs;
   logic [31:0] x_w1, x_w2, x_w3;

   always #5 clk = ~clk;

   sha_pre_pipeline_scheduler #(
      .PROCESSORINDEX(1), .NUMPROCESSORS(4), .NONCE_LIMIT(33'd17), .PIPE_LATENCY(PL)
   ) u_d0 (
      .clk(clk), .rst(rst), .work_valid(work_valid), .work_ready(wr[0]),
      .work_hashstate(work_hs), .work_w1(ww1), .work_w2(ww2), .work_w3(ww3),
      .hold(hold), .abort(abort), .core_valid(cv[0]), .core_newblock(nb[0]),
      .core_hashstate(chs[0]), .core_w1(cw1[0]), .core_w2(cw2[0]), .core_w3(cw3[0]),
      .busy(bsy[0]), .cur_nonce(cn[0]), .sweep_done(sd[0])
   );

   sha_pre_pipeline_scheduler #(
      .PROCESSORINDEX(32'hFFFF_FFF3), .NUMPROCESSORS(4), .NONCE_LIMIT(33'h1_0000_0000),
      .PIPE_LATENCY(PL)
   ) u_d1 (
      .clk(clk), .rst(rst), .work_valid(work_valid), .work_ready(wr[1]),
      .work_hashstate(work_hs), .work_w1(ww1), .work_w2(ww2), .work_w3(ww3),
      .hold(hold), .abort(abort), .core_valid(cv[1]), .core_newblock(nb[1]),
      .core_hashstate(chs[1]), .core_w1(cw1[1]), .core_w2(cw2[1]), .core_w3(cw3[1]),
      .busy(bsy[1]), .cur_nonce(cn[1]), .sweep_done(sd[1])
   );

   sha_pre_pipeline_scheduler #(
      .PROCESSORINDEX(20), .NUMPROCESSORS(4), .NONCE_LIMIT(33'd17), .PIPE_LATENCY(PL)
   ) u_d2 (
      .clk(clk), .rst(rst), .work_valid(wv3), .work_ready(wr[2]),
      .work_hashstate(work_hs), .work_w1(ww1), .work_w2(ww2), .work_w3(ww3),
      .hold(hold), .abort(abort), .core_valid(cv[2]), .core_newblock(nb[2]),
      .core_hashstate(chs[2]), .core_w1(cw1[2]), .core_w2(cw2[2]), .core_w3(cw3[2]),
      .busy(bsy[2]), .cur_nonce(cn[2]), .sweep_done(sd[2])
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic chk256(input string tag, input HashState obs, input HashState exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%064h expected=%064h", tag, obs, exp);
      end
   endtask

   function automatic longint p_pi(input int d);
      case (d)
         0:       return 64'd1;
         1:       return 64'hFFFF_FFF3;
         default: return 64'd20;
      endcase
   endfunction

   function automatic longint p_lim(input int d);
      return (d == 1) ? 64'h1_0000_0000 : 64'd17;
   endfunction

   // Build the expected per-cycle plan for scheduler d.
   task automatic plan(input int d, input logic [63:0] hm, input int ab);
      longint      n;
      int          k;
      int          last;
      bit          first;
      logic [31:0] cur;
      n = p_pi(d); k = 1; last = 0; first = 1'b1;
      for (int i = 0; i < 64; i++) begin
         e_valid[d][i] = 1'b0;
         e_nb[d][i]    = 1'b0;
      end
      cur = prev_cur[d];
      for (int i = 0; i < 64; i++) e_non[d][i] = cur;
      while (n < p_lim(d)) begin
         if (ABORT_EN && ab == k) break;
         if (!hm[k]) begin
            e_valid[d][k] = 1'b1;
            e_nb[d][k]    = first;
            first         = 1'b0;
            for (int i = k; i < 64; i++) e_non[d][i] = n[31:0];
            last = k;
            n    = n + 4;
         end
         k++;
      end
      if (n < p_lim(d)) last = k;
      e_done[d] = last + PL;
   endtask

   task automatic new_item();
      for (int i = 0; i < 8; i++) work_hs[i] = $urandom;
      ww1 = $urandom; ww2 = $urandom; ww3 = $urandom;
   endtask

   task automatic check_dut(input string name, input int d, input int k);
      string t;
      t = $sformatf("%s d%0d k%0d", name, d, k);
      chk1  ({t, " valid"},     cv[d],  e_valid[d][k]);
      chk1  ({t, " newblock"},  nb[d],  e_nb[d][k]);
      chk32 ({t, " cur_nonce"}, cn[d],  e_non[d][k]);
      chk1  ({t, " busy"},      bsy[d], (k >= 1) && (k <= e_done[d]));
      chk1  ({t, " sweep_done"},sd[d],  (k == e_done[d]));
      chk1  ({t, " work_ready"},wr[d],  (k >= e_done[d]));
      chk256({t, " hashstate"}, chs[d], x_hs);
      chk32 ({t, " w1"},        cw1[d], x_w1);
      chk32 ({t, " w2"},        cw2[d], x_w2);
      chk32 ({t, " w3"},        cw3[d], x_w3);
   endtask

   // pre  : item already accepted on the previous edge (work_valid held high)
   // keep : keep work_valid high across the sweep, offering a fresh item
   // en3  : also send the item to the empty-slice scheduler d2
   task automatic run_sweep(input string name, input bit pre, input bit keep, input bit en3,
                            input logic [63:0] hm, input int ab);
      int last;
      plan(0, hm, ab);
      plan(1, hm, ab);
      if (en3) plan(2, hm, ab);
      last = e_done[0];
      if (en3 && e_done[2] > last) last = e_done[2];
      if (!pre) begin
         new_item();
         chk1({name, " ready before accept"}, wr[0], 1'b1);
         work_valid = 1'b1;
         wv3        = en3;
         hold       = hm[0];
         abort      = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      x_hs = work_hs; x_w1 = ww1; x_w2 = ww2; x_w3 = ww3;
      work_valid = keep;
      wv3        = 1'b0;
      if (keep) new_item();
      for (int k = 0; k <= last; k++) begin
         check_dut(name, 0, k);
         check_dut(name, 1, k);
         if (en3) begin
            check_dut(name, 2, k);
         end else begin
            chk1({name, " d2 idle valid"}, cv[2], 1'b0);
            chk1({name, " d2 idle busy"},  bsy[2], 1'b0);
         end
         hold  = hm[k+1];
         abort = (ab == k + 1);
         @(posedge clk);
         @(negedge clk);
      end
      hold  = 1'b0;
      abort = 1'b0;
      prev_cur[0] = e_non[0][63];
      prev_cur[1] = e_non[1][63];
   endtask

   initial begin
      logic [63:0] hm;
      int          ab;
      bit          e3;

      rst = 1'b1; work_valid = 1'b0; wv3 = 1'b0; hold = 1'b0; abort = 1'b0;
      work_hs = '0; ww1 = '0; ww2 = '0; ww3 = '0;
      for (int d = 0; d < 3; d++) prev_cur[d] = '0;

      // reset state
      @(posedge clk); @(posedge clk); @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk1  ($sformatf("reset d%0d valid", d),      cv[d],  1'b0);
         chk1  ($sformatf("reset d%0d newblock", d),   nb[d],  1'b0);
         chk1  ($sformatf("reset d%0d busy", d),       bsy[d], 1'b0);
         chk1  ($sformatf("reset d%0d sweep_done", d), sd[d],  1'b0);
         chk1  ($sformatf("reset d%0d work_ready", d), wr[d],  1'b0);
         chk32 ($sformatf("reset d%0d cur_nonce", d),  cn[d],  32'h0);
         chk256($sformatf("reset d%0d hashstate", d),  chs[d], '0);
         chk32 ($sformatf("reset d%0d w1", d),         cw1[d], 32'h0);
      end
      rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) chk1($sformatf("post-reset d%0d work_ready", d), wr[d], 1'b1);
      @(negedge clk);

      // plain sweep and the spec's hold pattern
      run_sweep("basic", 1'b0, 1'b0, 1'b1, 64'h0, 0);
      run_sweep("hold13", 1'b0, 1'b0, 1'b1, 64'h0A, 0);

      // back-to-back items with work_valid held high
      hm = {32'h0, ($urandom & $urandom) & 32'h000F_FFFE};
      run_sweep("keep", 1'b0, 1'b1, 1'b0, hm, 0);
      run_sweep("second", 1'b1, 1'b0, 1'b0, 64'h0, 0);

      // randomised hold/abort patterns
      for (int i = 0; i < 6; i++) begin
         hm = {32'h0, ($urandom & $urandom) & 32'h000F_FFFE};
         ab = (i % 2 == 1) ? int'($urandom_range(1, 9)) : 0;
         e3 = bit'($urandom_range(0, 1));
         run_sweep($sformatf("rand%0d", i), 1'b0, 1'b0, e3, hm, ab);
      end

      // abort early, and abort coinciding with hold
      run_sweep("abort2", 1'b0, 1'b0, 1'b1, 64'h0, 2);
      run_sweep("abort_hold", 1'b0, 1'b0, 1'b0, 64'h18, 4);

      // reset in the middle of a sweep
      new_item();
      work_valid = 1'b1; wv3 = 1'b1;
      @(posedge clk); @(negedge clk);
      work_valid = 1'b0; wv3 = 1'b0;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk1  ($sformatf("midrst d%0d valid", d),      cv[d],  1'b0);
         chk1  ($sformatf("midrst d%0d busy", d),       bsy[d], 1'b0);
         chk1  ($sformatf("midrst d%0d sweep_done", d), sd[d],  1'b0);
         chk1  ($sformatf("midrst d%0d work_ready", d), wr[d],  1'b0);
         chk32 ($sformatf("midrst d%0d cur_nonce", d),  cn[d],  32'h0);
         chk256($sformatf("midrst d%0d hashstate", d),  chs[d], '0);
      end
      rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) chk1($sformatf("midrst d%0d ready after", d), wr[d], 1'b1);
      for (int d = 0; d < 3; d++) prev_cur[d] = '0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            chk1($sformatf("midrst idle d%0d k%0d sweep_done", d, k), sd[d],  1'b0);
            chk1($sformatf("midrst idle d%0d k%0d valid", d, k),      cv[d],  1'b0);
            chk1($sformatf("midrst idle d%0d k%0d busy", d, k),       bsy[d], 1'b0);
         end
      end

      // recovery after reset
      run_sweep("post_rst", 1'b0, 1'b0, 1'b1, 64'h4, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
